// File: rtl/sram_arb.sv
// rtl/sram_arb.sv - two-port arbiter and cycle sequencer for the external 16-bit async SRAM
module sram_arb #(
  parameter int WAIT   = 3,
  parameter bit PRIO_B = 1'b0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        a_req_i,
  input  logic [15:0] a_addr_i,
  input  logic        a_r_i,
  input  logic [1:0]  a_w_i,
  input  logic [15:0] a_wdata_i,
  output logic        a_ack_o,
  input  logic        b_req_i,
  input  logic [15:0] b_addr_i,
  input  logic        b_r_i,
  input  logic [1:0]  b_w_i,
  input  logic [15:0] b_wdata_i,
  output logic        b_ack_o,
  output logic [15:0] rdata_o,
  output logic        grant_o,
  output logic        busy_o,
  output logic [17:0] sram_addr_o,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        sram_ub_n_o,
  output logic        sram_lb_n_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_END} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [1:0]  w_q, w_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        grant_q, grant_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic        ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic        busy_q, busy_d;
  logic        win_b, is_rd, is_wr, in_acc;

  // Byte address bit 0 has no meaning on a 16-bit word SRAM.
  logic unused_addr_lsb;
  assign unused_addr_lsb = a_addr_i[0] ^ b_addr_i[0];

  // Next-state, latching and registered-output decode; strobes follow the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    w_d     = w_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    rdata_d = rdata_q;
    win_b   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (a_req_i || b_req_i) begin
          if (PRIO_B)                  win_b = b_req_i;
          else if (a_req_i && b_req_i) win_b = ~grant_q;
          else                         win_b = b_req_i;
          grant_d = win_b;
          addr_d  = win_b ? b_addr_i[15:1] : a_addr_i[15:1];
          rd_d    = win_b ? b_r_i : a_r_i;
          w_d     = win_b ? b_w_i : a_w_i;
          wdata_d = win_b ? b_wdata_i : a_wdata_i;
          cnt_d   = 4'(WAIT);
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_END;
          if (rd_q) rdata_d = sram_dq_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    is_rd   = rd_d;
    is_wr   = !rd_d && (w_d != 2'b00);
    in_acc  = (state_d == ST_ACC);
    ce_n_d  = !(in_acc && (is_rd || is_wr));
    oe_n_d  = !(in_acc && is_rd);
    we_n_d  = !(in_acc && is_wr);
    ub_n_d  = !(in_acc && (is_rd || (is_wr && w_d[1])));
    lb_n_d  = !(in_acc && (is_rd || (is_wr && w_d[0])));
    // Write data is driven through END for hold time after WE rises.
    dq_oe_d = is_wr && (in_acc || state_d == ST_END);
    a_ack_d = (state_d == ST_END) && !grant_d;
    b_ack_d = (state_d == ST_END) && grant_d;
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers; reset forces the bus inactive immediately.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 15'd0;
      rd_q    <= 1'b0;
      w_q     <= 2'b00;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      grant_q <= 1'b1;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      w_q     <= w_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      busy_q  <= busy_d;
    end
  end

  assign a_ack_o      = a_ack_q;
  assign b_ack_o      = b_ack_q;
  assign rdata_o      = rdata_q;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign sram_addr_o  = {3'b000, addr_q};
  assign sram_dq_o    = wdata_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_ub_n_o  = ub_n_q;
  assign sram_lb_n_o  = lb_n_q;

endmodule

// File: tb/tb_sram_arb.sv
// tb/tb_sram_arb.sv - directed vector bench for sram_arb (WAIT=3 RR, WAIT=3 B-prio, WAIT=0 RR)
module tb_sram_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset;
  logic mem_clr;

  logic        a_req[3], a_r[3], b_req[3], b_r[3];
  logic [15:0] a_addr[3], a_wdata[3], b_addr[3], b_wdata[3];
  logic [1:0]  a_w[3], b_w[3];
  logic        a_ack[3], b_ack[3], grant[3], busy[3], dq_oe[3];
  logic        ce_n[3], oe_n[3], we_n[3], ub_n[3], lb_n[3];
  logic [15:0] rdata[3], dq_o[3], dq_i[3];
  logic [17:0] saddr[3];

  int n_vec = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 2) ? 0 : 3;
    localparam bit P = (g == 1);
    sram_arb #(.WAIT(W), .PRIO_B(P)) u_dut (
      .clk(clk), .nreset(nreset),
      .a_req_i(a_req[g]), .a_addr_i(a_addr[g]), .a_r_i(a_r[g]), .a_w_i(a_w[g]),
      .a_wdata_i(a_wdata[g]), .a_ack_o(a_ack[g]),
      .b_req_i(b_req[g]), .b_addr_i(b_addr[g]), .b_r_i(b_r[g]), .b_w_i(b_w[g]),
      .b_wdata_i(b_wdata[g]), .b_ack_o(b_ack[g]),
      .rdata_o(rdata[g]), .grant_o(grant[g]), .busy_o(busy[g]),
      .sram_addr_o(saddr[g]), .sram_dq_i(dq_i[g]), .sram_dq_o(dq_o[g]),
      .sram_dq_oe_o(dq_oe[g]), .sram_ce_n_o(ce_n[g]), .sram_oe_n_o(oe_n[g]),
      .sram_we_n_o(we_n[g]), .sram_ub_n_o(ub_n[g]), .sram_lb_n_o(lb_n[g])
    );

    logic [15:0] mem [256];
    always @(posedge clk) begin
      if (mem_clr) begin
        for (int k = 0; k < 256; k++) mem[k] <= 16'h0000;
      end else if (!ce_n[g] && !we_n[g]) begin
        if (!ub_n[g]) mem[saddr[g][7:0]][15:8] <= dq_o[g][15:8];
        if (!lb_n[g]) mem[saddr[g][7:0]][7:0]  <= dq_o[g][7:0];
      end
    end
    assign dq_i[g] = mem[saddr[g][7:0]];
  end

  typedef struct {
    int          inst;
    bit          port;
    logic [15:0] addr;
    bit          r;
    logic [1:0]  w;
    logic [15:0] wdata;
    logic [17:0] exp_addr;
    int          exp_we;
    int          exp_oe;
    int          exp_dqoe;
    bit          exp_ub;
    bit          exp_lb;
    bit          chk_rd;
    logic [15:0] exp_rd;
    int          exp_ack;
  } vec_t;

  vec_t vtab[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic access(input int idx, input vec_t v);
    int          we_c = 0, oe_c = 0, dqoe_c = 0, ack_c = -1, other = 0;
    bit          ub_lo = 0, lb_lo = 0;
    logic [15:0] rd = '0;
    logic [17:0] ad = '0;
    logic        gr = 1'b0;
    int          i;
    i = v.inst;
    @(posedge clk); #1;
    if (v.port) begin
      b_req[i] = 1'b1; b_addr[i] = v.addr; b_r[i] = v.r; b_w[i] = v.w; b_wdata[i] = v.wdata;
    end else begin
      a_req[i] = 1'b1; a_addr[i] = v.addr; a_r[i] = v.r; a_w[i] = v.w; a_wdata[i] = v.wdata;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (!we_n[i]) we_c++;
      if (!oe_n[i]) oe_c++;
      if (dq_oe[i]) dqoe_c++;
      if (!ub_n[i]) ub_lo = 1'b1;
      if (!lb_n[i]) lb_lo = 1'b1;
      if (v.port ? a_ack[i] : b_ack[i]) other++;
      if (v.port ? b_ack[i] : a_ack[i]) begin
        ack_c = c; rd = rdata[i]; ad = saddr[i]; gr = grant[i];
        break;
      end
    end
    @(posedge clk); #1;
    a_req[i] = 1'b0;
    b_req[i] = 1'b0;
    chk($sformatf("v%0d ack_cycle", idx), ack_c, v.exp_ack);
    chk($sformatf("v%0d we_cycles", idx), we_c, v.exp_we);
    chk($sformatf("v%0d oe_cycles", idx), oe_c, v.exp_oe);
    chk($sformatf("v%0d dqoe_cycles", idx), dqoe_c, v.exp_dqoe);
    chk($sformatf("v%0d ub_low", idx), ub_lo, v.exp_ub);
    chk($sformatf("v%0d lb_low", idx), lb_lo, v.exp_lb);
    chk($sformatf("v%0d sram_addr", idx), ad, v.exp_addr);
    chk($sformatf("v%0d grant", idx), gr, v.port);
    chk($sformatf("v%0d other_ack", idx), other, 0);
    if (v.chk_rd) chk($sformatf("v%0d rdata", idx), rd, v.exp_rd);
  endtask

  initial begin
    int bad_cnt, a_at, b_cnt, both, n, a_pend, b_pend;
    int got[4];

    //           inst port addr    r  w      wdata    exp_addr we oe dqoe ub lb chk rd       ack
    vtab[0] = '{0, 0, 16'h02A4, 0, 2'b11, 16'hBEEF, 18'h00152, 4, 0, 5, 1, 1, 0, 16'h0000, 5};
    vtab[1] = '{0, 0, 16'h02A4, 1, 2'b00, 16'h0000, 18'h00152, 0, 4, 0, 1, 1, 1, 16'hBEEF, 5};
    vtab[2] = '{0, 0, 16'h02A6, 0, 2'b10, 16'h1234, 18'h00153, 4, 0, 5, 1, 0, 0, 16'h0000, 5};
    vtab[3] = '{0, 0, 16'h02A6, 1, 2'b00, 16'h0000, 18'h00153, 0, 4, 0, 1, 1, 1, 16'h1200, 5};
    vtab[4] = '{0, 0, 16'h0010, 0, 2'b00, 16'hFFFF, 18'h00008, 0, 0, 0, 0, 0, 1, 16'h1200, 5};
    vtab[5] = '{0, 0, 16'h02A4, 1, 2'b11, 16'h0000, 18'h00152, 0, 4, 0, 1, 1, 1, 16'hBEEF, 5};
    vtab[6] = '{0, 1, 16'h0100, 0, 2'b01, 16'hA55A, 18'h00080, 4, 0, 5, 0, 1, 0, 16'h0000, 5};
    vtab[7] = '{0, 1, 16'h0100, 1, 2'b00, 16'h0000, 18'h00080, 0, 4, 0, 1, 1, 1, 16'h005A, 5};
    vtab[8] = '{2, 0, 16'hFFFE, 0, 2'b11, 16'h0F0F, 18'h07FFF, 1, 0, 2, 1, 1, 0, 16'h0000, 2};
    vtab[9] = '{2, 0, 16'hFFFF, 1, 2'b00, 16'h0000, 18'h07FFF, 0, 1, 0, 1, 1, 1, 16'h0F0F, 2};

    for (int g = 0; g < 3; g++) begin
      a_req[g] = 0; a_r[g] = 0; a_w[g] = 0; a_addr[g] = 0; a_wdata[g] = 0;
      b_req[g] = 0; b_r[g] = 0; b_w[g] = 0; b_addr[g] = 0; b_wdata[g] = 0;
    end
    nreset  = 1'b0;
    mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst%0d strobes", g), {ce_n[g], oe_n[g], we_n[g], ub_n[g], lb_n[g]}, 5'b11111);
      chk($sformatf("rst%0d dq_oe", g), dq_oe[g], 0);
      chk($sformatf("rst%0d acks", g), {a_ack[g], b_ack[g]}, 2'b00);
      chk($sformatf("rst%0d busy", g), busy[g], 0);
      chk($sformatf("rst%0d rdata", g), rdata[g], 0);
      chk($sformatf("rst%0d grant", g), grant[g], 1);
      chk($sformatf("rst%0d addr_dq", g), {saddr[g], dq_o[g]}, 0);
    end
    nreset  = 1'b1;
    mem_clr = 1'b0;
    bad_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        if (busy[g] || a_ack[g] || b_ack[g] || !ce_n[g]) bad_cnt++;
    end
    chk("idle_20_cycles", bad_cnt, 0);

    for (int k = 0; k < 10; k++) access(k, vtab[k]);

    // Round robin on instance 0: both request together, each drops on ack and re-requests.
    a_addr[0] = 16'h0040; a_r[0] = 0; a_w[0] = 2'b00;
    b_addr[0] = 16'h0042; b_r[0] = 0; b_w[0] = 2'b00;
    @(posedge clk); #1;
    a_req[0] = 1'b1; b_req[0] = 1'b1;
    n = 0; both = 0; a_pend = 0; b_pend = 0;
    for (int c = 0; c < 80; c++) begin
      if (n >= 4) break;
      @(posedge clk); #1;
      if (a_pend == 1) begin a_req[0] = 1'b0; a_pend = 2; end
      else if (a_pend == 2) begin a_req[0] = 1'b1; a_pend = 0; end
      if (b_pend == 1) begin b_req[0] = 1'b0; b_pend = 2; end
      else if (b_pend == 2) begin b_req[0] = 1'b1; b_pend = 0; end
      @(negedge clk);
      if (a_ack[0] && b_ack[0]) both++;
      if (a_ack[0] && n < 4) begin got[n] = 0; n++; a_pend = 1; end
      if (b_ack[0] && n < 4) begin got[n] = 1; n++; b_pend = 1; end
    end
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_ack[0] && b_ack[0]) both++;
      if (!busy[0]) break;
    end
    chk("rr_count", n, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), got[k], k % 2);
    chk("rr_dual_ack", both, 0);
    chk("rr_idle", busy[0], 0);

    // Fixed B priority on instance 1: B holds req for three accesses, A waits.
    a_addr[1] = 16'h0010; a_r[1] = 0; a_w[1] = 2'b00;
    b_addr[1] = 16'h0020; b_r[1] = 0; b_w[1] = 2'b00;
    @(posedge clk); #1;
    a_req[1] = 1'b1; b_req[1] = 1'b1;
    b_cnt = 0; a_at = -1; both = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (b_cnt == 3) b_req[1] = 1'b0;
      @(negedge clk);
      if (a_ack[1] && b_ack[1]) both++;
      if (b_ack[1]) b_cnt++;
      if (a_ack[1]) begin a_at = b_cnt; break; end
    end
    @(posedge clk); #1;
    a_req[1] = 1'b0; b_req[1] = 1'b0;
    chk("prio_b_acks", b_cnt, 3);
    chk("prio_a_after_b", a_at, 3);
    chk("prio_dual_ack", both, 0);

    // Reset pulsed in the middle of a write on instance 0.
    repeat (2) @(posedge clk);
    #1;
    a_req[0] = 1'b1; a_addr[0] = 16'h0200; a_r[0] = 0; a_w[0] = 2'b11; a_wdata[0] = 16'h5555;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("rstmid we_n_pre", {we_n[0], ce_n[0], dq_oe[0]}, 3'b001);
    #2 nreset = 1'b0;
    #1;
    chk("rstmid strobes_async", {we_n[0], ce_n[0], oe_n[0]}, 3'b111);
    chk("rstmid dq_oe_async", dq_oe[0], 0);
    a_req[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    nreset = 1'b1;
    bad_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (a_ack[0] || b_ack[0] || busy[0]) bad_cnt++;
    end
    chk("rstmid no_ack", bad_cnt, 0);
    access(100, vtab[8]);
    access(101, vtab[9]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arb.md
# sram_arb

Two-port arbiter and cycle sequencer for the board's external 16-bit asynchronous SRAM. It sits between the SRAM pins and two bus masters: port A, normally the b16 CPU, and port B, normally the debug UART memory port. It grants the SRAM to one master at a time, generates CE/OE/WE/byte-lane strobes with a programmable wait-state count, and returns read data with a one-cycle acknowledge. It replaces ad-hoc master muxing and free-running READY wait-state counting in the top level.

## Interface
- WAIT, default 3: wait-state count; the access phase lasts WAIT+1 cycles (legal range 0..15).
- PRIO_B, default 0: 0 = round-robin between A and B; 1 = B has fixed priority.
- clk  in  1  system clock; all state changes on posedge.
- nreset  in  1  reset, asynchronous, active-low.
- a_req  in  1  port A request; held high until a_ack.
- a_addr  in  16  port A byte address; bit 0 ignored.
- a_r  in  1  port A read.
- a_w  in  2  port A byte write enables, [1]=high byte, [0]=low byte.
- a_wdata  in  16  port A write data.
- a_ack  out  1  port A completion pulse, one cycle.
- b_req, b_addr, b_r, b_w, b_wdata, b_ack: identical set for port B.
- rdata  out  16  read data register, shared; valid in the ack cycle and held until the next read completes.
- grant  out  1  owner of the current/last access (0=A, 1=B).
- busy  out  1  high when not IDLE.
- sram_addr  out  18  word address = {3'b000, addr[15:1]}.
- sram_dq_i  in  16  SRAM data from the pad.
- sram_dq_o  out  16  SRAM data to the pad.
- sram_dq_oe  out  1  pad output enable.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low.

## Operation
- States: IDLE, ACC, END.
- **IDLE**
  - If no request: remain in IDLE.
  - If a request is present: select the winner, latch its addr/r/w/wdata into internal registers, load cnt=WAIT, set grant, go to ACC.
  - Masters may change their inputs freely after latching.
- **Arbitration**
  - PRIO_B=1: B wins whenever b_req=1.
  - PRIO_B=0, both requesting: the port not granted last wins. The last-grant flag resets to B, so A wins the first tie.
  - PRIO_B=0, single request: that port wins.
- **Operation type**
  - r=1: read. w is ignored when r=1.
  - r=0, w≠0: write.
  - r=0, w=00: no-op. Completes with normal timing, all strobes stay inactive, rdata is unchanged.
- **ACC** (lasts WAIT+1 cycles, cnt counts down to 0)
  - Read: ce_n=0, oe_n=0, we_n=1, ub_n=lb_n=0, dq_oe=0. On the cycle with cnt=0, capture sram_dq_i into rdata.
  - Write: ce_n=0, oe_n=1, we_n=0, ub_n=~w[1], lb_n=~w[0], dq_oe=1, dq_o=latched wdata.
  - cnt==0: go to END.
- **END** (one cycle)
  - Assert the granted port's ack.
  - All strobes high (ce_n, oe_n, we_n, ub_n, lb_n).
  - On a write, dq_oe and dq_o are held one more cycle for data hold time, then dq_oe=0.
  - Go to IDLE.
- Outside a write's ACC/END cycles: dq_oe=0. sram_addr holds the last latched address.
- Reset values: state IDLE, all strobes 1, dq_oe 0, dq_o 0, sram_addr 0, rdata 0, a_ack/b_ack 0, grant 1, busy 0, cnt 0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Latency, with the request sampled in IDLE at edge 0:
  - ACC covers edges 1..WAIT+1.
  - ack is high from edge WAIT+2 to edge WAIT+3.
  - Total: WAIT+3 cycles from request sample to return to IDLE.
  - WAIT=3: ack in cycle 5; back-to-back throughput is one access per 6 cycles.
- Requester rules:
  - Deassert req on the edge where ack is seen.
  - A req still high in the IDLE cycle after END starts a new access.
- A request arriving during ACC/END waits and is served in the next IDLE. No request is dropped.
- Reset asserted mid-access: strobes go inactive and dq_oe goes low immediately (asynchronously). No ack is issued. State is IDLE after release.
- ack is never asserted on both ports in the same cycle.

## Test plan
- **Reset values:** nreset low → all strobes 1, dq_oe 0, acks 0, busy 0, rdata 0. Release with no requests → stays IDLE for 20 cycles.
- **A write/readback:** WAIT=3. A writes 16'hBEEF to 0x2A4 with w=11 → sram_addr=0x152, we_n low for 4 cycles, a_ack in cycle 5. A reads the same address with the model returning 0xBEEF → rdata=0xBEEF in the ack cycle.
- **Byte lanes:** w=10 write → ub_n=0, lb_n=1 during ACC. w=00, r=0 → ack in cycle 5 with no strobe low.
- **Tie, round-robin:** PRIO_B=0, A and B both request from the same cycle, each re-requesting after ack → grants A,B,A,B. Exactly one ack per access.
- **Tie, B priority:** PRIO_B=1 with B requesting continuously → A is never granted until b_req drops. A is then granted in the next IDLE.
- **Reset mid-write:** nreset pulsed during ACC → we_n/ce_n rise and dq_oe drops in the same cycle. No ack. A fresh request after release completes normally with WAIT=0 → ack in cycle 2.
